// File: rtl/cmd_display_buffer.sv
// rtl/cmd_display_buffer.sv - 7-segment history display for the command stream
// Newest byte sits in digit 0; older bytes shift up and the oldest falls off when full.
module cmd_display_buffer #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLINK_DIV    = 25_000_000,
    parameter int ASCII_DIGITS = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [7:0]                      in_data,
    input  logic                            clear,
    input  logic                            blink_en,
    output logic [NUM_DIGITS*7-1:0]         seg_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0] count,
    output logic                            full
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);
    localparam logic [BW-1:0] WRAP_CNT = BW'(BLINK_DIV - 1);
    localparam logic [6:0] BLANK = 7'h7F;

    logic [6:0]    slot [NUM_DIGITS];
    logic [BW-1:0] blink_cnt;
    logic          blink_hidden;
    logic          push;

    assign push = in_valid && !clear;
    assign full = (count == FULL_CNT);

    // Returns the active-low segment code; the table lists lit segments {a..g}.
    function automatic logic [6:0] decode(input logic [7:0] b);
        logic [7:0] v;
        logic [6:0] pat;
        v = b;
        if (ASCII_DIGITS != 0 && b >= 8'd48 && b <= 8'd57)
            v = b - 8'd48;
        case (v)
            8'd0:    pat = 7'h7E;
            8'd1:    pat = 7'h30;
            8'd2:    pat = 7'h6D;
            8'd3:    pat = 7'h79;
            8'd4:    pat = 7'h33;
            8'd5:    pat = 7'h5B;
            8'd6:    pat = 7'h5F;
            8'd7:    pat = 7'h70;
            8'd8:    pat = 7'h7F;
            8'd9:    pat = 7'h7B;
            8'd102:  pat = 7'h47;
            8'd114:  pat = 7'h05;
            8'd108:  pat = 7'h0E;
            default: pat = 7'h4F;
        endcase
        return ~pat;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_DIGITS; k++)
                slot[k] <= BLANK;
            count <= '0;
        end else if (clear) begin
            for (int k = 0; k < NUM_DIGITS; k++)
                slot[k] <= BLANK;
            count <= '0;
        end else if (push) begin
            for (int k = 1; k < NUM_DIGITS; k++)
                slot[k] <= slot[k-1];
            slot[0] <= decode(in_data);
            if (count != FULL_CNT)
                count <= count + 1'b1;
        end
    end

    // Any push or clear restarts the blink so a fresh byte is always visible at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (in_valid || clear || !blink_en || count == '0) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == WRAP_CNT) begin
            blink_cnt    <= '0;
            blink_hidden <= !blink_hidden;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        seg_out = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            seg_out[7*k +: 7] = slot[k];
        if (blink_hidden && blink_en)
            seg_out[6:0] = BLANK;
    end

endmodule

// File: tb/tb_cmd_display_buffer.sv
// tb/tb_cmd_display_buffer.sv - bench for cmd_display_buffer against a queue-based history model
// Two instances share stimulus: A (4 digits, blink 4, ASCII on), B (3 digits, blink 3, ASCII off).
module tb_cmd_display_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        clear;
    logic        blink_en;
    logic [27:0] seg_a;
    logic [2:0]  count_a;
    logic        full_a;
    logic [20:0] seg_b;
    logic [1:0]  count_b;
    logic        full_b;

    int checks = 0;
    int errors = 0;

    bit [7:0] hist_a[$];
    bit [7:0] hist_b[$];
    int       el_a = 0;
    int       el_b = 0;

    bit [6:0] dig_pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    cmd_display_buffer #(.NUM_DIGITS(4), .BLINK_DIV(4), .ASCII_DIGITS(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .blink_en(blink_en), .seg_out(seg_a), .count(count_a), .full(full_a));

    cmd_display_buffer #(.NUM_DIGITS(3), .BLINK_DIV(3), .ASCII_DIGITS(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .blink_en(blink_en), .seg_out(seg_b), .count(count_b), .full(full_b));

    always #5 clk = ~clk;

    function automatic bit [6:0] ref_code(bit [7:0] b, int ascii);
        bit [6:0] p;
        if (b < 8'd10)                              p = dig_pat[b];
        else if (ascii != 0 && b >= 48 && b <= 57)  p = dig_pat[b - 48];
        else if (b == 8'd102)                       p = 7'h47;
        else if (b == 8'd114)                       p = 7'h05;
        else if (b == 8'd108)                       p = 7'h0E;
        else                                        p = 7'h4F;
        return ~p;
    endfunction

    function automatic logic [31:0] ref_seg(bit [7:0] h[$], int n, int ascii, int el, int div);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            r[7*k +: 7] = (k < h.size()) ? ref_code(h[k], ascii) : 7'h7F;
        if (blink_en && h.size() > 0 && ((el / div) % 2) == 1)
            r[6:0] = 7'h7F;
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("seg_a",   32'(seg_a),   ref_seg(hist_a, 4, 1, el_a, 4));
        chk("count_a", 32'(count_a), 32'(hist_a.size()));
        chk("full_a",  32'(full_a),  32'(hist_a.size() == 4));
        chk("seg_b",   32'(seg_b),   ref_seg(hist_b, 3, 0, el_b, 3));
        chk("count_b", 32'(count_b), 32'(hist_b.size()));
        chk("full_b",  32'(full_b),  32'(hist_b.size() == 3));
    endtask

    // Elapsed idle cycles with blinking active; phase is (elapsed / div) mod 2.
    task automatic model_edge();
        if (reset) begin
            hist_a.delete(); hist_b.delete();
            el_a = 0; el_b = 0;
        end else begin
            el_a = (in_valid || clear || !blink_en || hist_a.size() == 0) ? 0 : el_a + 1;
            el_b = (in_valid || clear || !blink_en || hist_b.size() == 0) ? 0 : el_b + 1;
            if (clear) begin
                hist_a.delete(); hist_b.delete();
            end else if (in_valid) begin
                hist_a.push_front(in_data);
                hist_b.push_front(in_data);
                if (hist_a.size() > 4) void'(hist_a.pop_back());
                if (hist_b.size() > 3) void'(hist_b.pop_back());
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic push(bit [7:0] b);
        in_valid = 1'b1; in_data = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        hist_a.delete(); hist_b.delete();
        el_a = 0; el_b = 0;
        check_all();
        step();
        reset = 1'b0;
    endtask

    function automatic bit [7:0] rand_byte();
        bit [7:0] letters [3] = '{8'd102, 8'd114, 8'd108};
        case ($urandom % 4)
            0:       return 8'($urandom_range(0, 9));
            1:       return 8'($urandom_range(48, 57));
            2:       return letters[$urandom % 3];
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; clear = 1'b0; blink_en = 1'b0;
        @(negedge clk);
        check_all();
        chk("reset_seg_a", 32'(seg_a), 32'h0FFF_FFFF);
        reset = 1'b0;
        step();

        push(8'd102); push(8'd3); push(8'd114); push(8'd9);
        chk("fill_seg_a", 32'(seg_a), 32'({7'h38, 7'h06, 7'h7A, 7'h04}));
        chk("fill_full_a", 32'(full_a), 32'd1);
        push(8'd108);
        chk("shift_seg_a", 32'(seg_a), 32'({7'h06, 7'h7A, 7'h04, 7'h71}));
        chk("shift_count_a", 32'(count_a), 32'd4);

        push(8'd55);
        chk("ascii_on", 32'(seg_a[6:0]), 32'h0F);
        chk("ascii_off", 32'(seg_b[6:0]), 32'h30);
        push(8'd200);
        chk("other_byte", 32'(seg_a[6:0]), 32'h30);

        clear = 1'b1; in_valid = 1'b1; in_data = 8'd4;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_prio", 32'(seg_a), 32'h0FFF_FFFF);
        push(8'd1);
        chk("after_clear", 32'(seg_a[6:0]), 32'h4F);

        async_reset();
        blink_en = 1'b1;
        push(8'd5);
        for (int i = 0; i < 4; i++) step();
        chk("blink_hidden", 32'(seg_a[6:0]), 32'h7F);
        step();
        push(8'd7);
        chk("push_unhides", 32'(seg_a[6:0]), 32'h0F);
        for (int i = 0; i < 12; i++) step();

        push(8'd2); push(8'd8);
        @(negedge clk);
        #2 async_reset();

        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom % 100) < 35;
            clear    = ($urandom % 100) < 4;
            in_data  = rand_byte();
            if (($urandom % 50) == 0) blink_en = ~blink_en;
            if (($urandom % 150) == 0) begin
                in_valid = 1'b0; clear = 1'b0;
                async_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
